// File: rtl/fp_op_issuer.sv
// fp_op_issuer: command-side initiator for the Q8.23 fixed-point ALU.
// Accepts a request, drives operands/opcode/start to the ALU and waits a
// fixed latency (Add/Mul) or for done (Div, with timeout). It then returns
// the captured result with an error flag.
// Optional build macro: FPISSUE_STATS_EN adds the stat_ops/stat_errs counters.
module fp_op_issuer #(
   parameter int WIDTH       = 32,
   parameter int FIX_WAIT    = 2,
   parameter int DIV_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [1:0]       req_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_opcode,
   output logic             alu_start,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_done,
   output logic             busy
`ifdef FPISSUE_STATS_EN
   ,
   output logic [15:0]      stat_ops,
   output logic [15:0]      stat_errs
`endif
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT + FIX_WAIT + 1);
   localparam logic [CNT_W-1:0] FIX_LOAD = CNT_W'(FIX_WAIT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT_FIX, WAIT_DIV, RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [1:0]       r_alu_op;
   logic             r_alu_start;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_err;
   logic             w_accept;
   logic             w_div_done;
   logic             w_div_tmo;
   logic             w_fix_done;
   logic             w_rsp_hs;

   // Handshake and completion conditions; done is masked during the start
   // cycle so a level left over from a previous divide is not taken as ours.
   assign w_accept   = req_valid && (r_state == IDLE);
   assign w_div_done = alu_done && !r_alu_start;
   assign w_div_tmo  = !w_div_done && (r_cnt == DIV_LAST);
   assign w_fix_done = (r_cnt == '0);
   assign w_rsp_hs   = (r_state == RESP) && rsp_ready;

   assign req_ready  = (r_state == IDLE) && !rst;
   assign rsp_valid  = (r_state == RESP);
   assign busy       = (r_state != IDLE);
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_op;
   assign alu_start  = r_alu_start;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (req_op == OP_ADD || req_op == OP_MUL) w_next = WAIT_FIX;
               else if (req_op == OP_DIV)                w_next = WAIT_DIV;
               else                                      w_next = RESP;
            end
         end
         WAIT_FIX: if (w_fix_done) w_next = RESP;
         WAIT_DIV: if (w_div_done || w_div_tmo) w_next = RESP;
         RESP:     if (rsp_ready) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Operand capture, latency counter, start pulse and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= 2'b00;
         r_alu_start <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_alu_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_alu_a  <= req_a;
                  r_alu_b  <= req_b;
                  r_alu_op <= req_op;
                  if (req_op == OP_ADD || req_op == OP_MUL) begin
                     r_cnt <= FIX_LOAD;
                  end else if (req_op == OP_DIV) begin
                     r_alu_start <= 1'b1;
                     r_cnt       <= '0;
                  end else begin
                     r_rsp_data <= '0;
                     r_rsp_err  <= 1'b1;
                  end
               end
            end
            WAIT_FIX: begin
               if (w_fix_done) begin
                  r_rsp_data <= alu_c;
                  r_rsp_err  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            WAIT_DIV: begin
               if (w_div_done) begin
                  r_rsp_data <= alu_c;
                  r_rsp_err  <= 1'b0;
               end else if (w_div_tmo) begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RESP: if (rsp_ready) r_rsp_err <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef FPISSUE_STATS_EN
   logic [15:0] r_stat_ops;
   logic [15:0] r_stat_errs;

   assign stat_ops  = r_stat_ops;
   assign stat_errs = r_stat_errs;

   // Saturating counters of accepted requests and error responses delivered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_ops  <= '0;
         r_stat_errs <= '0;
      end else begin
         if (w_accept && r_stat_ops != 16'hFFFF) r_stat_ops <= r_stat_ops + 16'd1;
         if (w_rsp_hs && r_rsp_err && r_stat_errs != 16'hFFFF)
            r_stat_errs <= r_stat_errs + 16'd1;
      end
   end
`else
   logic w_unused_hs;
   assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: tb/tb_fp_op_issuer.sv
// Directed testbench for fp_op_issuer (WIDTH=32, FIX_WAIT=2, DIV_TIMEOUT=64).
module tb_fp_op_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [1:0]  alu_opcode;
   logic        alu_start;
   logic [31:0] alu_c;
   logic        alu_done;
   logic        busy;
`ifdef FPISSUE_STATS_EN
   logic [15:0] stat_ops;
   logic [15:0] stat_errs;
`endif

   int checks = 0;
   int errors = 0;
   int exp_ops = 0;
   int exp_errs = 0;

   fp_op_issuer #(.WIDTH(32), .FIX_WAIT(2), .DIV_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_start(alu_start), .alu_c(alu_c), .alu_done(alu_done),
      .busy(busy)
`ifdef FPISSUE_STATS_EN
      , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock; sample and drive 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 2'b00;
      rsp_ready = 1'b0; alu_c = '0; alu_done = 1'b0;
      step(); step();
      checks++;
      if ({rsp_valid, rsp_err, alu_start, busy, req_ready} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 00000", {rsp_valid, rsp_err, alu_start, busy, req_ready});
      end
      checks++;
      if ({alu_a, alu_b, alu_opcode, rsp_data} !== 98'b0) begin
         errors++; $display("FAIL reset_data got a=%h b=%h op=%b d=%h exp zeros", alu_a, alu_b, alu_opcode, rsp_data);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", req_ready);
      end
   endtask

   task automatic test_add();
      logic start_seen;
      start_seen = 1'b0;
      alu_c = 32'h0100_0000; rsp_ready = 1'b1;
      req_valid = 1'b1; req_a = 32'h0080_0000; req_b = 32'h0080_0000; req_op = 2'b00;
      step(); exp_ops++;
      req_valid = 1'b0;
      start_seen |= alu_start;
      checks++;
      if ({alu_a, alu_b, alu_opcode, busy, rsp_valid} !== {32'h0080_0000, 32'h0080_0000, 2'b00, 1'b1, 1'b0}) begin
         errors++; $display("FAIL add_issue got a=%h b=%h op=%b busy=%b v=%b", alu_a, alu_b, alu_opcode, busy, rsp_valid);
      end
      step();
      start_seen |= alu_start;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL add_early got rsp_valid=%b exp 0", rsp_valid);
      end
      step();
      start_seen |= alu_start;
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0100_0000}) begin
         errors++; $display("FAIL add_rsp got v=%b e=%b d=%h exp v=1 e=0 d=01000000", rsp_valid, rsp_err, rsp_data);
      end
      step();
      start_seen |= alu_start;
      checks++;
      if ({rsp_valid, req_ready, start_seen} !== 3'b010) begin
         errors++; $display("FAIL add_done got v=%b rdy=%b start_seen=%b exp 0 1 0", rsp_valid, req_ready, start_seen);
      end
   endtask

   task automatic test_div();
      logic early;
      early = 1'b0;
      rsp_ready = 1'b1; alu_c = 32'hDEAD_BEEF; alu_done = 1'b1;
      req_valid = 1'b1; req_a = 32'h0080_0000; req_b = 32'h0100_0000; req_op = 2'b10;
      step(); exp_ops++;
      req_valid = 1'b0;
      checks++;
      if ({alu_start, alu_opcode, rsp_valid} !== 4'b1100) begin
         errors++; $display("FAIL div_start got start=%b op=%b v=%b exp 1 10 0", alu_start, alu_opcode, rsp_valid);
      end
      step();
      checks++;
      if ({alu_start, rsp_valid, busy} !== 3'b001) begin
         errors++; $display("FAIL div_stale got start=%b v=%b busy=%b exp 0 0 1", alu_start, rsp_valid, busy);
      end
      alu_done = 1'b0;
      for (int i = 0; i < 19; i++) begin
         step();
         early |= rsp_valid | alu_start;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++; $display("FAIL div_wait got early=%b exp 0", early);
      end
      alu_c = 32'h0040_0000; alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0040_0000}) begin
         errors++; $display("FAIL div_rsp got v=%b e=%b d=%h exp v=1 e=0 d=00400000", rsp_valid, rsp_err, rsp_data);
      end
      step();
   endtask

   task automatic test_timeout();
      int n;
      rsp_ready = 1'b1; alu_done = 1'b0; alu_c = 32'h1111_1111;
      req_valid = 1'b1; req_a = 32'h0000_0001; req_b = 32'h0000_0000; req_op = 2'b10;
      step(); exp_ops++;
      req_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (n !== 64) begin
         errors++; $display("FAIL tmo_latency got %0d cycles exp 64", n);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
         errors++; $display("FAIL tmo_rsp got v=%b e=%b d=%h exp v=1 e=1 d=0", rsp_valid, rsp_err, rsp_data);
      end
      step(); exp_errs++;
   endtask

   task automatic test_illegal();
      rsp_ready = 1'b1; alu_c = 32'h2222_2222;
      req_valid = 1'b1; req_a = 32'h0000_0005; req_b = 32'h0000_0006; req_op = 2'b11;
      step(); exp_ops++;
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_data, alu_start} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         errors++; $display("FAIL ill_rsp got v=%b e=%b d=%h start=%b exp 1 1 0 0", rsp_valid, rsp_err, rsp_data, alu_start);
      end
      step(); exp_errs++;
      checks++;
      if ({rsp_valid, rsp_err, req_ready} !== 3'b001) begin
         errors++; $display("FAIL ill_clear got v=%b e=%b rdy=%b exp 0 0 1", rsp_valid, rsp_err, req_ready);
      end
`ifdef FPISSUE_STATS_EN
      checks++;
      if ({stat_ops, stat_errs} !== {exp_ops[15:0], exp_errs[15:0]}) begin
         errors++; $display("FAIL ill_stats got ops=%0d errs=%0d exp ops=%0d errs=%0d", stat_ops, stat_errs, exp_ops, exp_errs);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic unstable;
      unstable = 1'b0;
      rsp_ready = 1'b0; alu_c = 32'h1234_5678;
      req_valid = 1'b1; req_a = 32'h00C0_0000; req_b = 32'h0040_0000; req_op = 2'b01;
      step(); exp_ops++;
      req_a = 32'h0AAA_0000; req_b = 32'h0555_0000; req_op = 2'b00;
      step(); step();
      checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, 32'h1234_5678}) begin
         errors++; $display("FAIL b2b_rsp got v=%b d=%h exp v=1 d=12345678", rsp_valid, rsp_data);
      end
      for (int i = 0; i < 10; i++) begin
         alu_c = 32'h9000_0000 + i;
         step();
         unstable |= (rsp_valid !== 1'b1) | (rsp_data !== 32'h1234_5678) | (rsp_err !== 1'b0)
                   | (req_ready !== 1'b0) | (alu_a !== 32'h00C0_0000);
      end
      checks++;
      if (unstable !== 1'b0) begin
         errors++; $display("FAIL b2b_hold got unstable=%b exp 0", unstable);
      end
      rsp_ready = 1'b1;
      step();
      checks++;
      if ({rsp_valid, req_ready, alu_a} !== {1'b0, 1'b1, 32'h00C0_0000}) begin
         errors++; $display("FAIL b2b_hs got v=%b rdy=%b a=%h exp 0 1 00c00000", rsp_valid, req_ready, alu_a);
      end
      alu_c = 32'h0FFF_0000;
      step(); exp_ops++;
      req_valid = 1'b0;
      checks++;
      if ({alu_a, alu_b, alu_opcode} !== {32'h0AAA_0000, 32'h0555_0000, 2'b00}) begin
         errors++; $display("FAIL b2b_second got a=%h b=%h op=%b exp 0aaa0000 05550000 00", alu_a, alu_b, alu_opcode);
      end
      step(); step();
      checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, 32'h0FFF_0000}) begin
         errors++; $display("FAIL b2b_rsp2 got v=%b d=%h exp v=1 d=0fff0000", rsp_valid, rsp_data);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic spurious;
      spurious = 1'b0;
      rsp_ready = 1'b1; alu_done = 1'b0; alu_c = 32'h3333_3333;
      req_valid = 1'b1; req_a = 32'h0011_0000; req_b = 32'h0022_0000; req_op = 2'b10;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, rsp_err, alu_start, busy, req_ready, alu_opcode} !== 7'b0) begin
         errors++; $display("FAIL rstmid_ctrl got v=%b e=%b start=%b busy=%b rdy=%b op=%b exp zeros",
                            rsp_valid, rsp_err, alu_start, busy, req_ready, alu_opcode);
      end
      checks++;
      if ({alu_a, alu_b, rsp_data} !== 96'b0) begin
         errors++; $display("FAIL rstmid_data got a=%h b=%h d=%h exp zeros", alu_a, alu_b, rsp_data);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready);
      end
      alu_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         spurious |= rsp_valid | busy;
      end
      alu_done = 1'b0;
      checks++;
      if (spurious !== 1'b0) begin
         errors++; $display("FAIL rstmid_late_done got spurious=%b exp 0", spurious);
      end
`ifdef FPISSUE_STATS_EN
      checks++;
      if ({stat_ops, stat_errs} !== 32'h0) begin
         errors++; $display("FAIL rstmid_stats got ops=%0d errs=%0d exp 0 0", stat_ops, stat_errs);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_div();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion exp finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
